envia_cores_face: RTL
=====================

// Module: envia_cores_face
// PURPOSE
//  Sits downstream of ram_cores (the 3x3 RAM of identified face colours).
//  On iniciar, reads the nine 3-bit colour codes in row-major order and converts
//  each to an ASCII letter. Sends them as UART 8N1 frames to the host, followed by
//  a '\n' terminator, then pulses pronto (drives cores_transmitidas in the FD).
// PARAMETERS
//  CLKS_PER_BIT  434  clocks per UART bit (50 MHz / 115200 baud)
// PORTS
//  clock         in   1  system clock; all state on rising edge
//  reset         in   1  asynchronous, active-low reset
//  iniciar       in   1  start request; sampled only in OCIOSO
//  cor           in   3  ram_cores read data; valid 1 clock after address changes
//  linha_addr    out  2  ram_cores row address
//  coluna_addr   out  2  ram_cores column address
//  saida_serial  out  1  UART TX line; idle high
//  ocupado       out  1  high in every state except OCIOSO
//  pronto        out  1  1-clock pulse after the terminator stop bit ends
//  db_estado     out  4  current FSM state code, for debug
// BEHAVIOUR
//  Reset (reset=0, async): state OCIOSO, index=0, addr=0/0, saida_serial=1,
//   ocupado=0, pronto=0, db_estado=0. Reset mid-frame aborts at once: line high,
//   no partial frame resumes.
//  FSM states, with db_estado code in brackets:
//   OCIOSO[0] -> ENDERECA[1] when iniciar=1. Otherwise stay in OCIOSO.
//   ENDERECA[1] -> ESPERA_RAM[2]: drive linha=index/3, coluna=index%3.
//   ESPERA_RAM[2] -> CARREGA[3]: RAM read latency, 1 clock.
//   CARREGA[3] -> TRANSMITE[4]: latch ASCII(cor) into the shift register; clear
//    the baud and bit counters.
//   TRANSMITE[4] -> PROXIMO[5] after 10*CLKS_PER_BIT clocks.
//   PROXIMO[5]: index+1.
//    If new index<9 -> ENDERECA.
//    If new index=9 -> CARREGA_FIM[6] (latch 0x0A) -> TRANSMITE; after that
//     frame -> FIM.
//   FIM[7] -> OCIOSO: pronto=1 for this clock only; index cleared.
//  Timing:
//   - First start bit appears on the 4th clock after iniciar is sampled
//     (ENDERECA, ESPERA_RAM, CARREGA, then TRANSMITE).
//   - Between colour frames: exactly 4 idle-high clocks.
//   - Between frame 9 and the terminator: exactly 2 idle-high clocks.
//  Frame format:
//   - start bit 0, then 8 data bits LSB first, then stop bit 1.
//   - Each bit is held exactly CLKS_PER_BIT clocks.
//   - The baud counter is sized by $clog2(CLKS_PER_BIT) and wraps at
//     CLKS_PER_BIT-1.
//  ASCII map:
//   0->'W'(57h), 1->'Y'(59h), 2->'R'(52h), 3->'O'(4Fh), 4->'B'(42h),
//   5->'G'(47h), 6,7->'?'(3Fh).
//  iniciar while ocupado=1 is ignored entirely: no queueing.
//  iniciar=1 held through FIM restarts the cycle only after the return to
//   OCIOSO, one clock later.
//  Addresses hold their last value outside ENDERECA.
//   - ram_cores must not be written while ocupado=1 (FD controller's duty).
//  Total duration per face:
//   - clocks: 10 frames * 10*CLKS_PER_BIT, plus 3*9 load/address clocks,
//     plus 9 PROXIMO, plus 1 CARREGA_FIM, plus 1 FIM.
// TESTING (bench uses CLKS_PER_BIT=4)
//  1 RAM codes 0,1,2,3,4,5,0,1,2 -> bytes 57 59 52 4F 42 47 57 59 52 0A decoded
//    from saida_serial; exactly one pronto pulse; ocupado low afterwards.
//  2 Timing: iniciar at edge N -> start bit low from N+4. Gaps between colour
//    frames are 4 clocks; gap before the terminator is 2; pronto at end of FIM.
//  3 Codes 6 and 7 at positions (0,0) and (2,2) -> first and ninth bytes are 3Fh.
//  4 Pulse iniciar repeatedly mid-transmission -> byte stream and pronto count
//    unchanged (exactly 10 bytes, 1 pronto).
//  5 Assert reset during the data bits of byte 5 -> saida_serial=1 and
//    ocupado=0 immediately; a new iniciar then restarts from (0,0) with byte 1.
//  6 Address check -> linha/coluna sequence (0,0),(0,1)..(2,2). Each address is
//    stable for ESPERA_RAM and CARREGA; no address changes during TRANSMITE.

Source files
------------

// File: rtl/envia_cores_face.sv
// Reads the 3x3 face-colour RAM in row-major order and sends each colour as an
// ASCII letter over UART 8N1, followed by a '\n' terminator and a pronto pulse.
module envia_cores_face #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [2:0] cor,
    output logic [1:0] linha_addr,
    output logic [1:0] coluna_addr,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        ENDERECA    = 4'd1,
        ESPERA_RAM  = 4'd2,
        CARREGA     = 4'd3,
        TRANSMITE   = 4'd4,
        PROXIMO     = 4'd5,
        CARREGA_FIM = 4'd6,
        FIM         = 4'd7
    } estado_t;

    estado_t       estado_q;
    logic [3:0]    indice_q;
    logic [BW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [9:0]    quadro_q;
    logic [1:0]    linha_q;
    logic [1:0]    coluna_q;
    logic          saida_q;
    logic          ocupado_q;
    logic          pronto_q;

    function automatic logic [7:0] ascii_de(input logic [2:0] c);
        case (c)
            3'd0:    return 8'h57;
            3'd1:    return 8'h59;
            3'd2:    return 8'h52;
            3'd3:    return 8'h4F;
            3'd4:    return 8'h42;
            3'd5:    return 8'h47;
            default: return 8'h3F;
        endcase
    endfunction

    function automatic logic [1:0] linha_de(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd2: return 2'd0;
            4'd3, 4'd4, 4'd5: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] coluna_de(input logic [3:0] i);
        case (i)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            indice_q  <= 4'd0;
            baud_q    <= '0;
            bit_q     <= 4'd0;
            quadro_q  <= '1;
            linha_q   <= 2'd0;
            coluna_q  <= 2'd0;
            saida_q   <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            // NOTE: defaults first, so the line idles high and pronto stays a single-clock pulse.
            saida_q  <= 1'b1;
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        estado_q  <= ENDERECA;
                        ocupado_q <= 1'b1;
                    end
                end
                ENDERECA: begin
                    linha_q  <= linha_de(indice_q);
                    coluna_q <= coluna_de(indice_q);
                    estado_q <= ESPERA_RAM;
                end
                ESPERA_RAM: estado_q <= CARREGA;
                CARREGA: begin
                    quadro_q <= {1'b1, ascii_de(cor), 1'b0};
                    baud_q   <= '0;
                    bit_q    <= 4'd0;
                    estado_q <= TRANSMITE;
                end
                TRANSMITE: begin
                    // The line is registered, so it trails the state by one clock.
                    saida_q <= quadro_q[bit_q];
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 4'd9) begin
                            estado_q <= (indice_q == 4'd9) ? FIM : PROXIMO;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                PROXIMO: begin
                    indice_q <= indice_q + 4'd1;
                    estado_q <= (indice_q == 4'd8) ? CARREGA_FIM : ENDERECA;
                end
                CARREGA_FIM: begin
                    quadro_q <= {1'b1, 8'h0A, 1'b0};
                    baud_q   <= '0;
                    bit_q    <= 4'd0;
                    estado_q <= TRANSMITE;
                end
                FIM: begin
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                    indice_q  <= 4'd0;
                    estado_q  <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign linha_addr   = linha_q;
    assign coluna_addr  = coluna_q;
    assign saida_serial = saida_q;
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;
    assign db_estado    = estado_q;

endmodule
